// File: rtl/speck_iter_encrypt_pkg.sv
// -----------------------------------------------------------------------------
// speck_iter_encrypt_pkg
// Shared settings for the iterative SPECK-128/128 encryptor: word width,
// rotate constants, default round count, debug field widths, the state
// encoding and the rotate helpers used by the round function.
// -----------------------------------------------------------------------------
package speck_iter_encrypt_pkg;

   localparam int unsigned WORD_W        = 64;
   localparam int unsigned ALPHA         = 8;
   localparam int unsigned BETA          = 3;
   localparam int unsigned NR_ROUNDS_DEF = 32;
   localparam int unsigned CTR_W         = 6;
   localparam int unsigned STATE_W       = 4;

   // State encoding is visible on state_response, so the values are fixed.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 4'd0,
      ST_RUN  = 4'd1,
      ST_DONE = 4'd2
   } state_e;

   // Rotate right by a constant amount within one word.
   function automatic logic [WORD_W-1:0] ror_w(input logic [WORD_W-1:0] v,
                                               input int unsigned       amt);
      return (v >> amt) | (v << (WORD_W - amt));
   endfunction

   // Rotate left by a constant amount within one word.
   function automatic logic [WORD_W-1:0] rol_w(input logic [WORD_W-1:0] v,
                                               input int unsigned       amt);
      return (v << amt) | (v >> (WORD_W - amt));
   endfunction

endpackage

// File: rtl/speck_round_fn.sv
// -----------------------------------------------------------------------------
// speck_round_fn
// Purely combinational SPECK round function f(a, b, c):
//    a' = (ROR(a, ALPHA) + b) ^ c      (addition modulo 2^64)
//    b' = ROL(b, BETA) ^ a'
// Used once for the data path (a=x, b=y, c=round key) and once for the key
// schedule (a=l, b=k, c=round index).
// Ports:
//    a_i, b_i, c_i : 64-bit inputs
//    a_o, b_o      : 64-bit results
// -----------------------------------------------------------------------------
module speck_round_fn
   import speck_iter_encrypt_pkg::*;
(
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  logic [WORD_W-1:0] c_i,
   output logic [WORD_W-1:0] a_o,
   output logic [WORD_W-1:0] b_o
);

   assign a_o = (ror_w(a_i, ALPHA) + b_i) ^ c_i;
   assign b_o = rol_w(b_i, BETA) ^ a_o;

endmodule

// File: rtl/speck_iter_encrypt.sv
// -----------------------------------------------------------------------------
// speck_iter_encrypt
// Iterative SPECK-128/128 encryptor: one data round and one key-schedule
// round per clock, NR_ROUNDS rounds per block, block-level start/finished
// handshake.
// Ports:
//    clk            : rising-edge clock
//    rst            : synchronous active-high reset
//    signal_start   : encrypt request, only looked at in IDLE
//    plaintext      : [127:64] x word, [63:0] y word (captured on accept)
//    key            : [127:64] k0, [63:0] l0 (captured on accept)
//    ciphertext     : result, same layout as plaintext, held until the next
//                     encryption completes
//    finished       : one-cycle pulse when ciphertext becomes valid
//    busy           : high in RUN and DONE
//    round_ctr      : index of the round being executed (debug)
//    state_response : current state encoding (debug)
// -----------------------------------------------------------------------------
module speck_iter_encrypt
   import speck_iter_encrypt_pkg::*;
#(
   parameter int unsigned NR_ROUNDS = NR_ROUNDS_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signal_start,
   input  logic [2*WORD_W-1:0]  plaintext,
   input  logic [2*WORD_W-1:0]  key,
   output logic [2*WORD_W-1:0]  ciphertext,
   output logic                 finished,
   output logic                 busy,
   output logic [CTR_W-1:0]     round_ctr,
   output logic [STATE_W-1:0]   state_response
);

   localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(NR_ROUNDS - 1);

   state_e                state_q, state_d;
   logic [WORD_W-1:0]     x_q, x_d, y_q, y_d;
   logic [WORD_W-1:0]     k_q, k_d, l_q, l_d;
   logic [CTR_W-1:0]      ctr_q, ctr_d;
   logic [2*WORD_W-1:0]   ct_q, ct_d;
   logic                  fin_q, fin_d;
   logic                  busy_q, busy_d;

   logic [WORD_W-1:0]     x_rnd, y_rnd, l_rnd, k_rnd;
   logic [WORD_W-1:0]     round_idx;

   // The key schedule mixes in the round index, zero-extended to a word.
   assign round_idx = {{(WORD_W-CTR_W){1'b0}}, ctr_q};

   // Data round always consumes the key from before this cycle's key update.
   speck_round_fn u_data_rnd (
      .a_i (x_q),
      .b_i (y_q),
      .c_i (k_q),
      .a_o (x_rnd),
      .b_o (y_rnd)
   );

   speck_round_fn u_key_rnd (
      .a_i (l_q),
      .b_i (k_q),
      .c_i (round_idx),
      .a_o (l_rnd),
      .b_o (k_rnd)
   );

   // Next-state, datapath load/update and registered-output logic.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      k_d     = k_q;
      l_d     = l_q;
      ctr_d   = ctr_q;
      ct_d    = ct_q;

      case (state_q)
         ST_IDLE: begin
            if (signal_start) begin
               state_d = ST_RUN;
               x_d     = plaintext[2*WORD_W-1:WORD_W];
               y_d     = plaintext[WORD_W-1:0];
               k_d     = key[2*WORD_W-1:WORD_W];
               l_d     = key[WORD_W-1:0];
               ctr_d   = {CTR_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            x_d = x_rnd;
            y_d = y_rnd;
            if (ctr_q == LAST_CTR) begin
               // Final round: the key expansion result is not needed.
               state_d = ST_DONE;
               ct_d    = {x_rnd, y_rnd};
            end else begin
               state_d = ST_RUN;
               k_d     = k_rnd;
               l_d     = l_rnd;
               ctr_d   = ctr_q + 6'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are registered copies of where the FSM is going.
      fin_d  = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_q     <= {WORD_W{1'b0}};
         y_q     <= {WORD_W{1'b0}};
         k_q     <= {WORD_W{1'b0}};
         l_q     <= {WORD_W{1'b0}};
         ctr_q   <= {CTR_W{1'b0}};
         ct_q    <= {(2*WORD_W){1'b0}};
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         k_q     <= k_d;
         l_q     <= l_d;
         ctr_q   <= ctr_d;
         ct_q    <= ct_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
      end
   end

   assign ciphertext     = ct_q;
   assign finished       = fin_q;
   assign busy           = busy_q;
   assign round_ctr      = ctr_q;
   assign state_response = state_q;

endmodule

// File: doc/speck_iter_encrypt.md
# speck_iter_encrypt

Iterative SPECK-128/128 encryption engine that folds the full round chain into a single round datapath plus a single on-the-fly key-expansion datapath, executing one round per clock. It is the sequencing stage directly upstream of the per-round `round_encrypt` / `key_schedule` pair. It absorbs the start/finished handshaking currently done round-by-round into one block-level handshake, so a system integrates one encryptor instead of an `NR_ROUNDS`-long chain.

## Interface
- `NR_ROUNDS`, default 32, number of rounds executed. Legal range 1..32. Taken from `cipher_settings.vh`.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `signal_start` input 1: request to encrypt. Sampled only in IDLE.
- `plaintext` input 128: `[127:64]` = x word, `[63:0]` = y word. Captured on the accepting edge.
- `key` input 128: `[127:64]` = k0 (round-0 key), `[63:0]` = l0. Captured on the accepting edge.
- `ciphertext` output 128: same word layout as `plaintext`. Valid from `finished` until the next accepted start.
- `finished` output 1: one-cycle pulse when `ciphertext` becomes valid.
- `busy` output 1: high while in RUN or DONE.
- `round_ctr` output 6: index of the round being executed. Debug use.
- `state_response` output 4: current state encoding. Debug use.

## Operation
- Round function f(a, b, c):
  - a' = (ROR64(a,8) + b) ^ c, where + is mod 2^64;
  - b' = ROL64(b,3) ^ a'.
- Data path per round i: (x, y) ← f(x, y, k).
- Key path in the same cycle: (l, k) ← f(l, k, i), where i is zero-extended to 64 bits.
- The data path always uses the k value from before that cycle's key update.
- States, encoded 0 = IDLE, 1 = RUN, 2 = DONE:
  - IDLE: if `signal_start`, load x/y from `plaintext` and k/l from `key`, clear ctr, and go to RUN. Otherwise stay.
  - RUN: apply one round. If ctr == `NR_ROUNDS`-1, register the result into `ciphertext` and go to DONE. Otherwise increment ctr.
  - DONE: `finished` = 1 for this single cycle, then go to IDLE unconditionally.
- `signal_start` is ignored in RUN and DONE. No queuing and no abort.
- Input ports are not used after the accepting edge. The caller may change them freely.
- The key expansion for the final round is computed but discarded.

## Timing
- Reset values: state IDLE, `ciphertext` 0, `finished` 0, `busy` 0, `round_ctr` 0, `state_response` 0. Internal x/y/k/l registers are also 0.
- Reset takes priority over every other condition. Asserting `rst` mid-RUN aborts the encryption with no `finished` pulse; the engine is ready for a start in the cycle after `rst` deasserts.
- Latency: start accepted at edge E, `finished` high in the cycle following edge E+`NR_ROUNDS`.
  - For 32 rounds this is 32 cycles from the start edge to `finished`.
- Throughput: one block per `NR_ROUNDS`+2 cycles (34 cycles for 32 rounds). `signal_start` held high continuously restarts on the edge that leaves IDLE.
- `ciphertext` is updated only on the RUN→DONE edge and holds through IDLE. It does not change on the next accept; it changes only when the next encryption completes.
- `round_ctr` holds its value in DONE/IDLE until the next accept clears it.

## Structure
- `cipher_settings.vh` holds:
  - `NR_ROUNDS`;
  - the rotate constants ALPHA = 8 and BETA = 3;
  - the word width of 64;
  - the state encodings IDLE/RUN/DONE.
- Sub-module `speck_round_fn`: purely combinational implementation of f(a, b, c) with 64-bit ports. It is instantiated twice, once for the data path and once for the key path. The same module can later replace the arithmetic inside `round_encrypt` and `key_schedule`.

## Test plan
- Known-answer test (32 rounds):
  - stimulus: `key` = 128'h0706050403020100_0f0e0d0c0b0a0908, `plaintext` = 128'h6c61766975716520_7469206564616d20, one-cycle start;
  - response: `ciphertext` = 128'ha65d9851797832657_860fedf5c570d18 with digits regrouped as 128'ha65d985179783265_7860fedf5c570d18, `finished` exactly 32 cycles after the start edge and exactly one cycle wide.
- Start ignored while busy: pulse `signal_start` again at cycles 5 and 33 with different plaintext → the first result is unaffected and exactly one `finished` pulse occurs.
- Back-to-back: hold `signal_start` high and change `plaintext` after each accept → two correct known-answer results, with `finished` pulses 34 cycles apart.
- Reset mid-run: assert `rst` at cycle 10 of RUN → all outputs return to their reset values, no `finished` pulse. A following known-answer test passes.
- `NR_ROUNDS` = 1 with all-zero key and plaintext → `ciphertext` = 0, `finished` 1 cycle after the start edge.
- Input volatility: change `plaintext` and `key` randomly every cycle after the accept → the result still matches the known-answer test.
